mem_sweep_ctrl: RTL and testbench
=================================

Name: mem_sweep_ctrl

Overview:
- Sequencer for the single-port-pair BRAM memory block: raddr/waddr, din, registered dout, no write enable.
- Performs whole-array FILL (write a seeded pattern) and CHECK (read back, compare, count mismatches) sweeps.
- Used for bitstream memory-reinit experiments: fill, reconfigure, then check.
- Because the memory writes every clock, this block owns the write port at all times. Outside FILL it issues either write-back of the word just read, or a write to a reserved park address.

Parameters:
- WID_MEM, 5, memory word width.
- DEPTH_MEM, 2048, memory depth. Address DEPTH_MEM-1 is the park address and is never swept. Swept range is 0..N-1 with N = DEPTH_MEM-1.
- ERR_W, 16, width of the saturating mismatch counter.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  command strobe; sampled only in IDLE.
- op  in  2  0=FILL, 1=CHECK, 2=FILL_THEN_CHECK, 3=reserved (ignored).
- seed  in  WID_MEM  pattern base; latched at start.
- abort  in  1  return to IDLE next cycle.
- busy  out  1  high in any non-IDLE state.
- done  out  1  one-cycle pulse at sweep completion.
- err_cnt  out  ERR_W  mismatches in last CHECK; saturates at all-ones.
- first_err_vld  out  1  at least one mismatch seen.
- first_err_addr  out  32  address of first mismatch.
- mem_raddr  out  32  to memory raddr.
- mem_waddr  out  32  to memory waddr.
- mem_din  out  WID_MEM  to memory din.
- mem_dout  in  WID_MEM  from memory dout; 1-cycle read latency.

Behaviour:
- Pattern: exp(a) = (seed + a) mod 2^WID_MEM, with a truncated to WID_MEM bits.
- States: IDLE, FILL, CHECK, DRAIN, DONE.
- Reset: state=IDLE; busy=0; done=0; err_cnt=0; first_err_vld=0; first_err_addr=0; mem_raddr=N; mem_waddr=N (park); mem_din=0; wb_vld=0.
- IDLE: raddr=waddr=park. On start with op 0..2: clear stats, latch op and seed, addr=0. Transition: FILL for op 0/2, CHECK for op 1. op 3 → stay IDLE, no done. start while busy is ignored.
- Timing below: start is sampled at cycle T; outputs are registered.
- FILL: one write per cycle, waddr=a, din=exp(a), a = 0..N-1 during cycles T+1..T+N; raddr held at park. After a=N-1: op 0 → DONE; op 2 → CHECK with addr=0.
- CHECK: raddr=a each cycle. Read pipeline register carries (a, vld) one cycle.
- Write-back rule: in the cycle after a read of a, waddr=a and din=mem_dout, so contents are preserved. When no valid read is in flight, waddr=park.
- Compare: mem_dout vs exp(a) in the same cycle as write-back. On mismatch, err_cnt++ (saturating); the first mismatch also sets first_err_vld and first_err_addr.
- After read of N-1 → DRAIN (last compare/write-back only) → DONE.
- DONE: done=1 for one cycle → IDLE. Stats hold until next accepted start.
- done timing: op 0 at T+N+1; op 1 at T+N+2; op 2 at T+2N+2.
- abort in any busy state:
  - Next cycle IDLE, no done.
  - A pending write-back still completes that cycle; waddr goes to park afterwards.
  - Stats are frozen as-is.
- abort and start in the same cycle in IDLE: start wins.
- reset mid-operation: immediate reset values; memory contents are undefined only at the park address.

Decomposition:
- Package mem_ctrl_pkg: op_t enum (OP_FILL, OP_CHECK, OP_FILL_CHECK, OP_RSVD); state_t enum; helper function exp_pattern(seed, addr).
- One sub-module: mem_sweep_err_tracker. Holds the saturating ERR_W counter and first-mismatch capture; inputs clr, cmp_vld, mismatch, addr.

Test Plan:
- Reset, idle 20 cycles → busy=0, done=0, mem_waddr=mem_raddr=2047 every cycle, err_cnt=0.
- FILL seed=3 at T → done at T+2048; backdoor read mem[a]=(3+a)%32 for a<2047, e.g. mem[40]=11.
- FILL seed=0 then CHECK seed=0 → done at T+2049, err_cnt=0, first_err_vld=0, memory unchanged.
- FILL seed=0 then CHECK seed=1 → err_cnt=2047, first_err_addr=0. Repeat with ERR_W=8 → err_cnt=255.
- FILL_THEN_CHECK seed=7 → done at T+4096, err_cnt=0. start pulses while busy → no effect.
- FILL seed=0 then CHECK seed=0, abort at cycle T+500 → IDLE at T+501, no done, err_cnt=0, mem[0..498] intact. Reset asserted mid-CHECK → all outputs at reset values next cycle.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types and pattern helper for the BRAM fill/check sweep sequencer.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_FILL       = 2'd0,
    OP_CHECK      = 2'd1,
    OP_FILL_CHECK = 2'd2,
    OP_RSVD       = 2'd3
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_CHECK = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Full-width sum; callers truncate to the word width, which gives the modulo.
  function automatic logic [31:0] exp_pattern(input logic [31:0] seed,
                                              input logic [31:0] addr);
    return seed + addr;
  endfunction

endpackage

// File: rtl/mem_sweep_err_tracker.sv
// Saturating mismatch counter with capture of the first mismatching address.
module mem_sweep_err_tracker #(
  parameter int unsigned ERR_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             cmp_vld,
  input  logic             mismatch,
  input  logic [31:0]      addr,
  output logic [ERR_W-1:0] err_cnt,
  output logic             first_err_vld,
  output logic [31:0]      first_err_addr
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      err_cnt        <= '0;
      first_err_vld  <= 1'b0;
      first_err_addr <= '0;
    end else if (cmp_vld && mismatch) begin
      if (err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
      if (!first_err_vld) begin
        first_err_vld  <= 1'b1;
        first_err_addr <= addr;
      end
    end
  end

endmodule

// File: rtl/mem_sweep_ctrl.sv
// Whole-array FILL / CHECK sequencer that owns the BRAM write port every cycle;
// outside FILL it writes back the word just read, or parks at the top address.
module mem_sweep_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned WID_MEM   = 5,
  parameter int unsigned DEPTH_MEM = 2048,
  parameter int unsigned ERR_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WID_MEM-1:0] seed,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic [ERR_W-1:0]   err_cnt,
  output logic               first_err_vld,
  output logic [31:0]        first_err_addr,
  output logic [31:0]        mem_raddr,
  output logic [31:0]        mem_waddr,
  output logic [WID_MEM-1:0] mem_din,
  input  logic [WID_MEM-1:0] mem_dout
);

  localparam logic [31:0] PARK = 32'(DEPTH_MEM - 1);
  localparam logic [31:0] LAST = 32'(DEPTH_MEM - 2);

  state_t             state;
  op_t                op_q;
  logic [WID_MEM-1:0] seed_q;
  logic [WID_MEM-1:0] din_q;
  logic               wb_vld;
  logic               accept_c;
  logic               cmp_vld_c;
  logic               mismatch_c;

  assign accept_c   = (state == ST_IDLE) && start && (op_t'(op) != OP_RSVD);
  // An aborted cycle still writes back, but its compare is dropped so stats freeze.
  assign cmp_vld_c  = wb_vld && !abort;
  // mem_waddr doubles as the read-pipeline address while a write-back is pending.
  assign mismatch_c = mem_dout != WID_MEM'(exp_pattern(32'(seed_q), mem_waddr));
  assign mem_din    = wb_vld ? mem_dout : din_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      op_q      <= OP_FILL;
      seed_q    <= '0;
      din_q     <= '0;
      wb_vld    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_raddr <= PARK;
      mem_waddr <= PARK;
    end else if (abort && (state != ST_IDLE)) begin
      state     <= ST_IDLE;
      wb_vld    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_raddr <= PARK;
      mem_waddr <= PARK;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          mem_raddr <= PARK;
          mem_waddr <= PARK;
          wb_vld    <= 1'b0;
          if (accept_c) begin
            seed_q <= seed;
            op_q   <= op_t'(op);
            busy   <= 1'b1;
            if (op_t'(op) == OP_CHECK) begin
              state     <= ST_CHECK;
              mem_raddr <= '0;
            end else begin
              state     <= ST_FILL;
              mem_waddr <= '0;
              din_q     <= WID_MEM'(exp_pattern(32'(seed), '0));
            end
          end
        end
        ST_FILL: begin
          if (mem_waddr == LAST) begin
            mem_waddr <= PARK;
            if (op_q == OP_FILL_CHECK) begin
              state     <= ST_CHECK;
              mem_raddr <= '0;
            end else begin
              state <= ST_DONE;
              done  <= 1'b1;
            end
          end else begin
            mem_waddr <= mem_waddr + 32'd1;
            din_q     <= WID_MEM'(exp_pattern(32'(seed_q), mem_waddr + 32'd1));
          end
        end
        ST_CHECK: begin
          mem_waddr <= mem_raddr;
          wb_vld    <= 1'b1;
          if (mem_raddr == LAST) begin
            mem_raddr <= PARK;
            state     <= ST_DRAIN;
          end else begin
            mem_raddr <= mem_raddr + 32'd1;
          end
        end
        ST_DRAIN: begin
          mem_waddr <= PARK;
          wb_vld    <= 1'b0;
          state     <= ST_DONE;
          done      <= 1'b1;
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  mem_sweep_err_tracker #(
    .ERR_W(ERR_W)
  ) u_err (
    .clk           (clk),
    .reset         (reset),
    .clr           (accept_c),
    .cmp_vld       (cmp_vld_c),
    .mismatch      (mismatch_c),
    .addr          (mem_waddr),
    .err_cnt       (err_cnt),
    .first_err_vld (first_err_vld),
    .first_err_addr(first_err_addr)
  );

endmodule

// File: tb/tb_mem_sweep_ctrl.sv
// Scoreboard bench: two sequencers (16- and 8-bit counters) in lockstep, each on its own memory model.
module tb_mem_sweep_ctrl;

  localparam int N     = 2047;
  localparam int DEPTH = 2048;

  logic        clk = 1'b0;
  logic        reset, start, abort;
  logic [1:0]  op;
  logic [4:0]  seed;

  logic        busy, done, first_err_vld;
  logic [15:0] err_cnt;
  logic [31:0] first_err_addr, mem_raddr, mem_waddr;
  logic [4:0]  mem_din, mem_dout;

  logic        busy8, done8, first_err_vld8;
  logic [7:0]  err_cnt8;
  logic [31:0] first_err_addr8, mem_raddr8, mem_waddr8;
  logic [4:0]  mem_din8, mem_dout8;

  logic [4:0]  mem  [0:DEPTH-1];
  logic [4:0]  mem8 [0:DEPTH-1];
  logic [4:0]  ref_mem [0:DEPTH-1];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  typedef struct {
    int cyc;
    int err;
    int fvld;
    int faddr;
  } exp_t;
  exp_t sbq[$];
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_sweep_ctrl #(.WID_MEM(5), .DEPTH_MEM(DEPTH), .ERR_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .seed(seed), .abort(abort),
    .busy(busy), .done(done), .err_cnt(err_cnt), .first_err_vld(first_err_vld),
    .first_err_addr(first_err_addr), .mem_raddr(mem_raddr), .mem_waddr(mem_waddr),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  mem_sweep_ctrl #(.WID_MEM(5), .DEPTH_MEM(DEPTH), .ERR_W(8)) dut8 (
    .clk(clk), .reset(reset), .start(start), .op(op), .seed(seed), .abort(abort),
    .busy(busy8), .done(done8), .err_cnt(err_cnt8), .first_err_vld(first_err_vld8),
    .first_err_addr(first_err_addr8), .mem_raddr(mem_raddr8), .mem_waddr(mem_waddr8),
    .mem_din(mem_din8), .mem_dout(mem_dout8)
  );

  // Simple dual-port BRAM models: write every clock, registered read.
  always @(posedge clk) begin
    mem[mem_waddr[10:0]]   <= mem_din;
    mem_dout               <= mem[mem_raddr[10:0]];
    mem8[mem_waddr8[10:0]] <= mem_din8;
    mem_dout8              <= mem8[mem_raddr8[10:0]];
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sbq.size() == 0) begin
        chk("done_without_expect", int'(done), 0);
      end else begin
        mon_e = sbq.pop_front();
        chk("done_cycle", cyc, mon_e.cyc);
        chk("err_cnt", int'(err_cnt), (mon_e.err > 65535) ? 65535 : mon_e.err);
        chk("err_cnt_w8", int'(err_cnt8), (mon_e.err > 255) ? 255 : mon_e.err);
        chk("first_err_vld", int'(first_err_vld), mon_e.fvld);
        chk("first_err_addr", int'(first_err_addr), mon_e.faddr);
        chk("done_w8", int'(done8), 1);
      end
    end
  end

  task automatic launch(input logic [1:0] o, input logic [4:0] s, output int t);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    seed  = s;
    @(negedge clk);
    start = 1'b0;
    t     = cyc;
  endtask

  // Reference: fill rewrites the array with the pattern, check counts words off-pattern.
  task automatic model_push(input logic [1:0] o, input logic [4:0] s, input int t);
    exp_t e;
    int   lat;
    e.err = 0; e.fvld = 0; e.faddr = 0;
    if (o != 2'd1)
      for (int a = 0; a < N; a++) ref_mem[a] = 5'((int'(s) + a) % 32);
    if (o != 2'd0)
      for (int a = 0; a < N; a++)
        if (ref_mem[a] != 5'((int'(s) + a) % 32)) begin
          if (e.fvld == 0) begin e.fvld = 1; e.faddr = a; end
          e.err++;
        end
    lat   = (o == 2'd0) ? N + 1 : (o == 2'd1) ? N + 2 : 2 * N + 2;
    e.cyc = t + lat - 1;
    sbq.push_back(e);
  endtask

  task automatic wait_idle(input int maxc);
    int k = 0;
    while (busy && k < maxc) begin
      @(negedge clk);
      k++;
    end
    chk("idle_timeout", int'(busy), 0);
  endtask

  task automatic check_mem(input string name);
    int bad = 0;
    for (int a = 0; a < N; a++)
      if (mem[a] != ref_mem[a] || mem8[a] != ref_mem[a]) bad++;
    chk(name, bad, 0);
  endtask

  task automatic corrupt(input int k);
    for (int i = 0; i < k; i++) begin
      int a = $urandom_range(0, N - 1);
      ref_mem[a] = ref_mem[a] ^ 5'($urandom_range(1, 31));
      mem[a]     = ref_mem[a];
      mem8[a]    = ref_mem[a];
    end
  endtask

  initial begin
    int t;
    logic [1:0] o;
    logic [4:0] s;
    logic [4:0] w40;
    reset = 1'b1; start = 1'b0; abort = 1'b0; op = 2'd0; seed = 5'd0;
    for (int a = 0; a < DEPTH; a++) ref_mem[a] = 5'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Idle: everything parked
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_busy", int'(busy), 0);
      chk("idle_done", int'(done), 0);
      chk("idle_waddr", int'(mem_waddr), 2047);
      chk("idle_raddr", int'(mem_raddr), 2047);
      chk("idle_err", int'(err_cnt), 0);
    end

    // FILL seed 3 with backdoor inspection
    launch(2'd0, 5'd3, t); model_push(2'd0, 5'd3, t); wait_idle(5000);
    w40 = mem[40];
    chk("mem40", int'(w40), 11);
    check_mem("fill3_contents");

    // FILL 0 then CHECK 0: clean
    launch(2'd0, 5'd0, t); model_push(2'd0, 5'd0, t); wait_idle(5000);
    launch(2'd1, 5'd0, t); model_push(2'd1, 5'd0, t); wait_idle(5000);
    check_mem("check0_unchanged");

    // CHECK with the wrong seed: every word mismatches, 8-bit counter saturates
    launch(2'd1, 5'd1, t); model_push(2'd1, 5'd1, t); wait_idle(5000);
    check_mem("check1_unchanged");

    // FILL_THEN_CHECK with start pulses while busy
    launch(2'd2, 5'd7, t); model_push(2'd2, 5'd7, t);
    repeat (10) @(negedge clk);
    start = 1'b1; op = 2'd1; seed = 5'd9;
    @(negedge clk); start = 1'b0;
    repeat (2080) @(negedge clk);
    start = 1'b1; op = 2'd0; seed = 5'd2;
    @(negedge clk); start = 1'b0;
    wait_idle(5000);
    check_mem("fc7_contents");

    // Reserved op is ignored
    launch(2'd3, 5'd4, t);
    repeat (3) @(negedge clk);
    chk("rsvd_busy", int'(busy), 0);

    // Abort mid-CHECK
    launch(2'd0, 5'd0, t); model_push(2'd0, 5'd0, t); wait_idle(5000);
    launch(2'd1, 5'd0, t);
    repeat (499) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_waddr", int'(mem_waddr), 2047);
    chk("abort_err", int'(err_cnt), 0);
    repeat (5) @(negedge clk);
    check_mem("abort_contents");

    // Reset mid-CHECK after errors accumulated
    launch(2'd1, 5'd1, t);
    repeat (300) @(negedge clk);
    chk("pre_reset_err", int'(err_cnt), 299);
    chk("pre_reset_err_w8", int'(err_cnt8), 255);
    reset = 1'b1;
    sbq.delete();
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err_cnt), 0);
    chk("rst_fvld", int'(first_err_vld), 0);
    chk("rst_faddr", int'(first_err_addr), 0);
    chk("rst_raddr", int'(mem_raddr), 2047);
    chk("rst_waddr", int'(mem_waddr), 2047);
    chk("rst_din", int'(mem_din), 0);
    reset = 1'b0;
    check_mem("reset_contents");

    // Randomized sweeps with occasional corruption between them
    for (int i = 0; i < 6; i++) begin
      o = 2'($urandom_range(0, 2));
      s = 5'($urandom);
      @(negedge clk);
      if ($urandom_range(0, 1) == 1) corrupt($urandom_range(1, 4));
      launch(o, s, t); model_push(o, s, t); wait_idle(5000);
      check_mem("rand_contents");
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
